// File: rtl/event_seq_pkg.sv
// Shared types and helpers for the event trigger sequencer.
package event_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    FIRE = 2'd2,
    DONE = 2'd3
  } state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/event_gap_timer.sv
// Loadable down-counter that spaces successive event fires.
module event_gap_timer
  import event_seq_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] value_q;
  logic [TW-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (dec && (value_q != '0)) begin
      value_d = value_q - TW'(1);
    end else begin
      value_d = value_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero = (value_q == '0);

endmodule

// File: rtl/event_trigger_seq.sv
// Fires one-cycle pulses on each event line in index order, GAP_CYCLES apart,
// scoring every fire as a hit or a miss against the waiter's arm level.
module event_trigger_seq
  import event_seq_pkg::*;
#(
  parameter int  NUM_EVENTS = 3,
  parameter int  GAP_CYCLES = 100,
  parameter int  CNT_W      = 8,
  localparam int IW         = idx_w(NUM_EVENTS),
  localparam int TW         = idx_w(GAP_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  arm,
  output logic [NUM_EVENTS-1:0] evt,
  output logic [IW-1:0]         evt_idx,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt
);

  state_e                state_q, state_d;
  logic [NUM_EVENTS-1:0] evt_q, evt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  last_q, last_d;
  logic [CNT_W-1:0]      hit_q, hit_d;
  logic [CNT_W-1:0]      miss_q, miss_d;
  logic                  tmr_load;
  logic                  tmr_dec;
  logic                  tmr_zero;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  event_gap_timer #(.TW(TW)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(GAP_CYCLES - 1)),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // The fire edge reloads the timer itself so the next gap is exactly
  // GAP_CYCLES long; FIRE therefore counts just like GAP.
  always_comb begin
    state_d  = state_q;
    evt_d    = '0;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    last_d   = last_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          idx_d    = '0;
          busy_d   = 1'b1;
          last_d   = 1'b0;
          hit_d    = '0;
          miss_d   = '0;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      GAP, FIRE: begin
        if ((state_q == FIRE) && last_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          last_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d = FIRE;
          evt_d   = NUM_EVENTS'(1) << idx_q;
          if (arm) begin
            hit_d = sat_inc(hit_q);
          end else begin
            miss_d = sat_inc(miss_q);
          end
          if (idx_q == IW'(NUM_EVENTS - 1)) begin
            last_d = 1'b1;
          end else begin
            idx_d    = idx_q + IW'(1);
            tmr_load = 1'b1;
          end
        end else begin
          state_d = GAP;
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      evt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign evt      = evt_q;
  assign evt_idx  = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_event_trigger_seq.sv
// Randomized scoreboard bench: two sequencer configurations share one stimulus
// stream and are checked against a schedule-based reference model.
module tb_event_trigger_seq;

  localparam int N0 = 4;
  localparam int G0 = 3;
  localparam int C0 = 2;
  localparam int N1 = 3;
  localparam int G1 = 1;
  localparam int C1 = 8;
  localparam int NUM_CYC = 3000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic arm;

  logic [N0-1:0] evt0;
  logic [1:0]    idx0;
  logic          busy0, done0;
  logic [C0-1:0] hit0, miss0;
  logic [N1-1:0] evt1;
  logic [1:0]    idx1;
  logic          busy1, done1;
  logic [C1-1:0] hit1, miss1;

  always #5 clk = ~clk;

  event_trigger_seq #(.NUM_EVENTS(N0), .GAP_CYCLES(G0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .arm(arm),
    .evt(evt0), .evt_idx(idx0), .busy(busy0), .done(done0),
    .hit_cnt(hit0), .miss_cnt(miss0)
  );

  event_trigger_seq #(.NUM_EVENTS(N1), .GAP_CYCLES(G1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .arm(arm),
    .evt(evt1), .evt_idx(idx1), .busy(busy1), .done(done1),
    .hit_cnt(hit1), .miss_cnt(miss1)
  );

  typedef struct packed {
    logic [7:0] evt;
    logic [7:0] idx;
    logic [7:0] hit;
    logic [7:0] miss;
    logic       busy;
    logic       done;
    logic       chk_idx;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int  vectors = 0;
  int  miscompares = 0;
  longint t_edge = 0;

  // Reference model state: a sequence is just its launch edge t0.
  int     m_n[2];
  int     m_g[2];
  int     m_cw[2];
  bit     m_active[2];
  longint m_t0[2];
  int     m_hit[2];
  int     m_miss[2];

  function automatic exp_t model_step(input int d);
    exp_t   e;
    longint k;
    int     n, g, sat;
    e   = '0;
    n   = m_n[d];
    g   = m_g[d];
    sat = (1 << m_cw[d]) - 1;
    e.chk_idx = 1'b1;
    if (rst) begin
      m_active[d] = 1'b0;
      m_hit[d]    = 0;
      m_miss[d]   = 0;
    end else begin
      if (m_active[d] && (t_edge - m_t0[d]) >= longint'(n * g + 2)) m_active[d] = 1'b0;
      if (!m_active[d] && start) begin
        m_active[d] = 1'b1;
        m_t0[d]     = t_edge;
        m_hit[d]    = 0;
        m_miss[d]   = 0;
      end
      if (m_active[d]) begin
        k = t_edge - m_t0[d];
        e.busy = (k <= longint'(n * g));
        e.done = (k == longint'(n * g + 1));
        if (k >= longint'(g) && k <= longint'(n * g) && (k % g) == 0) begin
          e.evt     = 8'(1) << (k / g - 1);
          e.chk_idx = 1'b0;
          if (arm) begin
            if (m_hit[d] < sat) m_hit[d]++;
          end else begin
            if (m_miss[d] < sat) m_miss[d]++;
          end
        end else if (e.busy) begin
          e.idx = 8'(k / g);
        end
      end
    end
    e.hit  = 8'(m_hit[d]);
    e.miss = 8'(m_miss[d]);
    return e;
  endfunction

  task automatic check(input int d, input exp_t e, input exp_t a);
    bit bad;
    vectors++;
    bad = (e.evt != a.evt) || (e.busy != a.busy) || (e.done != a.done) ||
          (e.hit != a.hit) || (e.miss != a.miss) || (e.chk_idx && (e.idx != a.idx));
    if (bad) begin
      miscompares++;
      $display("FAIL dut%0d edge=%0d outputs: got evt=%h idx=%0d busy=%0b done=%0b hit=%0d miss=%0d, want evt=%h idx=%0d%s busy=%0b done=%0b hit=%0d miss=%0d",
               d, t_edge, a.evt, a.idx, a.busy, a.done, a.hit, a.miss,
               e.evt, e.idx, e.chk_idx ? "" : "(any)", e.busy, e.done, e.hit, e.miss);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; pop the expectation and compare.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        a = '0;
        a.evt = 8'(evt0); a.idx = 8'(idx0); a.busy = busy0; a.done = done0;
        a.hit = 8'(hit0); a.miss = 8'(miss0);
        check(0, e, a);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        a = '0;
        a.evt = 8'(evt1); a.idx = 8'(idx1); a.busy = busy1; a.done = done1;
        a.hit = 8'(hit1); a.miss = 8'(miss1);
        check(1, e, a);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    t_edge++;
    q0.push_back(model_step(0));
    q1.push_back(model_step(1));
  endtask

  initial begin
    int arm_mode;
    m_n[0] = N0; m_g[0] = G0; m_cw[0] = C0;
    m_n[1] = N1; m_g[1] = G1; m_cw[1] = C1;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_t0[d] = 0; m_hit[d] = 0; m_miss[d] = 0;
    end
    rst = 1'b1; start = 1'b0; arm = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Whole sequence unarmed: miss counter of the 2-bit config saturates at 3.
    @(negedge clk); rst = 1'b0; start = 1'b1; arm = 1'b0;
    step();
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < N0 * G0 + 2; i++) step();
    // Restart right after done clears the counters.
    @(negedge clk); start = 1'b1; arm = 1'b1;
    step();
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < N0 * G0 + 3; i++) step();

    arm_mode = 0;
    for (int c = 0; c < NUM_CYC; c++) begin
      @(negedge clk);
      if ((c % 40) == 0) arm_mode = int'($urandom_range(0, 2));
      rst   = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 5) == 0);
      case (arm_mode)
        0:       arm = 1'b0;
        1:       arm = 1'b1;
        default: arm = $urandom_range(0, 1) == 1;
      endcase
      step();
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    step();
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
